// File: rtl/xy_dac_scheduler.sv
// Time-shares the X/Y oscilloscope DAC pair between two point sources.
// Round-robin arbitration on sample ticks; each point is shown blanked (SETTLE) then lit (DWELL).
module xy_dac_scheduler #(
  parameter int DAC_BITS     = 8,
  parameter int TICK_DIV     = 12,
  parameter int SETTLE_TICKS = 1,
  parameter int DWELL_TICKS  = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                req0_valid,
  input  logic [DAC_BITS-1:0] req0_x,
  input  logic [DAC_BITS-1:0] req0_y,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DAC_BITS-1:0] req1_x,
  input  logic [DAC_BITS-1:0] req1_y,
  output logic                req1_ready,
  output logic [DAC_BITS-1:0] x_dac,
  output logic [DAC_BITS-1:0] y_dac,
  output logic                blank,
  output logic                grant,
  output logic [15:0]         point_count
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PMAX = (SETTLE_TICKS > DWELL_TICKS) ? SETTLE_TICKS : DWELL_TICKS;
  localparam int CW   = $clog2(PMAX + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_TICKS);
  localparam logic [CW-1:0] DWELL_LOAD  = CW'(DWELL_TICKS);
  localparam logic [CW-1:0] PH_ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DWELL
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] ph_cnt, ph_cnt_nx;
  logic          last_grant;
  logic          tick;
  logic          phase_end;
  logic          accept_slot;
  logic          winner;
  logic          transfer;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_ONE;
    end
  end

  assign tick      = enable && (tick_cnt == TICK_LAST);
  // ph_cnt holds the ticks remaining in the current phase, so 1 marks its final tick
  assign phase_end = (ph_cnt == PH_ONE);

  always_comb begin
    accept_slot = tick && ((state == IDLE) || ((state == DWELL) && phase_end));
    winner      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    transfer    = reset_n && accept_slot && (req0_valid || req1_valid);
    req0_ready  = transfer && !winner;
    req1_ready  = transfer && winner;
  end

  always_comb begin
    state_nx  = state;
    ph_cnt_nx = ph_cnt;
    case (state)
      SETTLE: begin
        if (tick) begin
          if (phase_end) begin
            state_nx  = DWELL;
            ph_cnt_nx = DWELL_LOAD;
          end else begin
            ph_cnt_nx = ph_cnt - PH_ONE;
          end
        end
      end
      DWELL: begin
        if (tick) begin
          if (phase_end) begin
            state_nx = IDLE;
          end else begin
            ph_cnt_nx = ph_cnt - PH_ONE;
          end
        end
      end
      default: ;
    endcase
    // a transfer on the final dwell tick overrides the return to IDLE
    if (transfer) begin
      if (SETTLE_TICKS == 0) begin
        state_nx  = DWELL;
        ph_cnt_nx = DWELL_LOAD;
      end else begin
        state_nx  = SETTLE;
        ph_cnt_nx = SETTLE_LOAD;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ph_cnt      <= '0;
      x_dac       <= '0;
      y_dac       <= '0;
      blank       <= 1'b1;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      point_count <= '0;
    end else begin
      state  <= state_nx;
      ph_cnt <= ph_cnt_nx;
      blank  <= (state_nx != DWELL);
      if (transfer) begin
        x_dac       <= winner ? req1_x : req0_x;
        y_dac       <= winner ? req1_y : req0_y;
        grant       <= winner;
        last_grant  <= winner;
        point_count <= point_count + 16'd1;
      end
    end
  end

endmodule
